// File: rtl/sdram_word_bridge.sv
// Bridges 32-bit CPU word accesses onto a byte-wide SDRAM controller as up to four
// sequential little-endian byte transactions, with per-byte timeout and read reassembly.
module sdram_word_bridge #(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [31:0]       i_cpu_wdata,
  input  logic [3:0]        i_cpu_be,
  output logic [31:0]       o_cpu_rdata,
  output logic              o_cpu_done,
  output logic              o_cpu_err,
  output logic              o_cpu_busy,
  output logic              o_mem_request,
  output logic              o_mem_wren,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [7:0]        o_mem_data,
  input  logic [7:0]        i_mem_data,
  input  logic              i_mem_done
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_nx;
  logic [1:0]        idx_q, idx_nx;
  logic [CNT_W-1:0]  tcnt_q;
  logic              err_q;
  logic              we_q;
  logic [ADDR_W-3:0] base_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [23:0]       rbuf_q;
  logic [31:0]       rdata_q;
  logic              accept, issue, capture, expire, skip;
  logic              unused_addr_lo;

  // Word base is always 4-aligned; the low address bits carry no information.
  assign unused_addr_lo = ^i_cpu_addr[1:0];

  always_comb begin
    state_nx = state_q;
    idx_nx   = idx_q;
    accept   = 1'b0;
    issue    = 1'b0;
    capture  = 1'b0;
    expire   = 1'b0;
    skip     = we_q && !be_q[idx_q];
    case (state_q)
      S_IDLE: begin
        if (i_cpu_req) begin
          accept   = 1'b1;
          idx_nx   = 2'd0;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (skip) begin
          if (idx_q == 2'd3) state_nx = S_DONE;
          else begin
            idx_nx   = idx_q + 2'd1;
            state_nx = S_ISSUE;
          end
        end else begin
          issue    = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_done) begin
          capture = 1'b1;
          if (idx_q == 2'd3) state_nx = S_DONE;
          else begin
            idx_nx   = idx_q + 2'd1;
            state_nx = S_ISSUE;
          end
        end else if (tcnt_q == CNT_TOP) begin
          expire   = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_nx;
      idx_q   <= idx_nx;
      if (accept) begin
        we_q    <= i_cpu_we;
        base_q  <= i_cpu_addr[ADDR_W-1:2];
        wdata_q <= i_cpu_wdata;
        be_q    <= i_cpu_be;
      end
      if (issue) tcnt_q <= '0;
      else if (state_q == S_WAIT && !i_mem_done) tcnt_q <= tcnt_q + 1'b1;
      if (expire) err_q <= 1'b1;
      else if (state_q == S_DONE) err_q <= 1'b0;
      // The last byte lands directly in the visible word so it is valid in the done cycle.
      if (capture && !we_q) begin
        case (idx_q)
          2'd0: rbuf_q[7:0]   <= i_mem_data;
          2'd1: rbuf_q[15:8]  <= i_mem_data;
          2'd2: rbuf_q[23:16] <= i_mem_data;
          default: rdata_q    <= {i_mem_data, rbuf_q};
        endcase
      end
    end
  end

  assign o_cpu_busy    = (state_q != S_IDLE);
  assign o_cpu_done    = (state_q == S_DONE);
  assign o_cpu_err     = (state_q == S_DONE) && err_q;
  assign o_cpu_rdata   = rdata_q;
  assign o_mem_request = issue;
  assign o_mem_wren    = we_q && (state_q == S_ISSUE || state_q == S_WAIT);
  assign o_mem_address = {base_q, idx_q};
  assign o_mem_data    = wdata_q[{idx_q, 3'b000} +: 8];

endmodule
